// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the stream reader, the FIFO read port and the
// downstream byte consumer.
interface fifo_stream_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] data_out;
    logic             data_out_valid;
    logic             data_out_ready;

    modport master (
        input  fifo_empty, fifo_dout, data_out_ready,
        output fifo_rd_en, data_out, data_out_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, data_out_ready,
        input  fifo_rd_en, data_out, data_out_valid
    );
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// stream_skid_buffer: 2-entry registered buffer feeding a valid/ready stream.
// Output data and valid come straight from registers.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);
    localparam int DEPTH = 2;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic                        head_q;
    logic [1:0]                  count_q, count_d;
    logic                        tail;
    logic                        pop;

    assign pop     = valid_o && ready_i;
    // With one-bit pointers the tail is the head offset by count mod 2;
    // at count==2 with a pop the freed head slot is the correct write target.
    assign tail    = head_q ^ count_q[0];
    assign count_d = count_q + {1'b0, push_i} - {1'b0, pop};
    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[head_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            head_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (push_i) mem_q[tail] <= data_i;
            if (pop)    head_q      <= ~head_q;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (data one cycle after rd_en) into a registered
// valid/ready byte stream and counts delivered bytes.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic [CNT_WIDTH-1:0]  bytes_sent,
    fifo_stream_reader_if.master  bus
);
    logic                 pending_q;
    logic [CNT_WIDTH-1:0] bytes_sent_q;
    logic [1:0]           count;
    logic                 pop;
    logic [2:0]           credit;

    assign pop    = bus.data_out_valid && bus.data_out_ready;
    // Credits: bytes held plus the byte due next cycle, minus the one leaving now.
    assign credit = {1'b0, count} + {2'b00, pending_q} - {2'b00, pop};
    assign bus.fifo_rd_en = !rst && enable && !bus.fifo_empty && (credit < 3'd2);
    assign bytes_sent = bytes_sent_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            pending_q    <= bus.fifo_rd_en;
            bytes_sent_q <= bytes_sent_q + {{(CNT_WIDTH-1){1'b0}}, pop};
        end
    end

    stream_skid_buffer #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pending_q),
        .data_i  (bus.fifo_dout),
        .valid_o (bus.data_out_valid),
        .ready_i (bus.data_out_ready),
        .data_o  (bus.data_out),
        .count_o (count)
    );
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO in front, scoreboard behind.
module tb_fifo_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic [15:0] bytes_sent;
    logic [3:0]  bytes_sent4;
    logic        rd_s;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    logic [7:0] exp_q[$];
    logic [7:0] fq[$];

    fifo_stream_reader_if #(.WIDTH(8)) bus ();
    fifo_stream_reader_if #(.WIDTH(8)) bus4 ();

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bytes_sent(bytes_sent), .bus(bus));

    // Shadow instance with a 4-bit counter, fed the same inputs.
    assign bus4.fifo_empty     = bus.fifo_empty;
    assign bus4.fifo_dout      = bus.fifo_dout;
    assign bus4.data_out_ready = bus.data_out_ready;
    fifo_stream_reader #(.WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .bytes_sent(bytes_sent4), .bus(bus4));

    // Behavioural synchronous FIFO; rd_en sampled mid-cycle to avoid edge races.
    always @(negedge clk) rd_s = bus.fifo_rd_en;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            bus.fifo_empty <= 1'b1;
            bus.fifo_dout  <= 8'h00;
        end else begin
            if (rd_s && fq.size() > 0) bus.fifo_dout <= fq.pop_front();
            if (wr_en) fq.push_back(wr_data);
            bus.fifo_empty <= (fq.size() == 0);
        end
    end

    // Scoreboard and hold-stability monitor.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!bus.data_out_valid || bus.data_out !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                             bus.data_out_valid, bus.data_out, prev_data);
                end
            end
            if (bus.data_out_valid && bus.data_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: data=%02h required no output", bus.data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.data_out !== e) begin
                        errors++;
                        $display("FAIL sb_data: data=%02h required %02h", bus.data_out, e);
                    end
                end
            end
            prev_stall = bus.data_out_valid && !bus.data_out_ready;
            prev_data  = bus.data_out;
        end
    end

    task automatic write_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            wr_en   = 1'b1;
            wr_data = first + 8'(i);
            exp_q.push_back(wr_data);
            delivered++;
        end
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.data_out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        delivered = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'h00 || bytes_sent !== 16'h0 || bus.fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL por_state: valid=%0b data=%02h sent=%0d rd=%0b required 0/00/0/0",
                     bus.data_out_valid, bus.data_out, bytes_sent, bus.fifo_rd_en);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.data_out_ready = 1'b1;
        write_bytes(8'h11, 1);
        enable = 1'b1;
        #1;
        checks++;
        if (bus.fifo_rd_en !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_rd: rd=%0b required 1", bus.fifo_rd_en);
        end
        rst = 1'b1;
        exp_q.delete();
        delivered = 0;
        #1;
        checks++;
        if (bus.fifo_rd_en !== 1'b0 || bus.data_out_valid !== 1'b0 || bus.data_out !== 8'h00 || bytes_sent !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: rd=%0b valid=%0b data=%02h sent=%0d required 0/0/00/0",
                     bus.fifo_rd_en, bus.data_out_valid, bus.data_out, bytes_sent);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.data_out_valid !== 1'b0 || bytes_sent !== 16'h0) begin
            errors++;
            $display("FAIL post_reset: valid=%0b sent=%0d required 0/0", bus.data_out_valid, bytes_sent);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        bit found;
        int rds;
        bit ok;
        found = 1'b0;
        write_bytes(8'hA5, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL single_rd: no read within 10 cycles, required one");
        end
        @(negedge clk);
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL single_n1: valid=%0b rd=%0b required 0/0", bus.data_out_valid, bus.fifo_rd_en);
        end
        @(negedge clk);
        checks++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_n2: valid=%0b data=%02h required 1/a5", bus.data_out_valid, bus.data_out);
        end
        rds = 0;
        repeat (5) begin @(negedge clk); if (bus.fifo_rd_en) rds++; end
        checks++;
        if (rds != 0) begin
            errors++;
            $display("FAIL single_extra_rd: reads=%0d required 0", rds);
        end
        wait_drain(ok);
        checks++;
        if (!ok || bytes_sent !== 16'd1) begin
            errors++;
            $display("FAIL single_sent: drained=%0b sent=%0d required 1/1", ok, bytes_sent);
        end
    endtask

    task automatic test_burst();
        int run, maxrun;
        bit ok;
        run = 0; maxrun = 0;
        fork
            write_bytes(8'h00, 32);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.data_out_valid) run++; else run = 0;
                if (run > maxrun) maxrun = run;
            end
        join
        wait_drain(ok);
        checks++;
        if (maxrun != 32) begin
            errors++;
            $display("FAIL burst_run: consecutive valid=%0d required 32", maxrun);
        end
        checks++;
        if (!ok || bytes_sent !== 16'd33 || bus.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL burst_end: drained=%0b sent=%0d empty=%0b required 1/33/1", ok, bytes_sent, bus.fifo_empty);
        end
    endtask

    task automatic test_backpressure();
        int rds;
        bit ok;
        enable = 1'b0;
        bus.data_out_ready = 1'b0;
        write_bytes(8'h40, 8);
        enable = 1'b1;
        rds = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rds++;
            @(posedge clk); #1;
        end
        checks++;
        if (rds != 2) begin
            errors++;
            $display("FAIL bp_reads: reads while stalled=%0d required 2", rds);
        end
        for (int i = 0; i < 40; i++) begin
            bus.data_out_ready = ~bus.data_out_ready;
            @(posedge clk); #1;
        end
        bus.data_out_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || bytes_sent !== 16'(delivered)) begin
            errors++;
            $display("FAIL bp_end: drained=%0b sent=%0d required 1/%0d", ok, bytes_sent, delivered);
        end
    endtask

    task automatic test_enable();
        bit found;
        int rds, outs;
        bit ok;
        found = 1'b0;
        enable = 1'b0;
        write_bytes(8'h60, 4);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.fifo_rd_en) begin found = 1'b1; break; end
        end
        @(posedge clk); #1;
        enable = 1'b0;
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL en_first_rd: no read issued, required one");
        end
        rds = 0; outs = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.fifo_rd_en) rds++;
            if (bus.data_out_valid) outs++;
        end
        checks++;
        if (rds != 0 || outs != 1 || exp_q.size() != 3) begin
            errors++;
            $display("FAIL en_off: reads=%0d outputs=%0d left=%0d required 0/1/3", rds, outs, exp_q.size());
        end
        @(posedge clk); #1;
        enable = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || bytes_sent !== 16'(delivered)) begin
            errors++;
            $display("FAIL en_resume: drained=%0b sent=%0d required 1/%0d", ok, bytes_sent, delivered);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        write_bytes(8'h80, 17);
        wait_drain(ok);
        checks++;
        if (!ok || bytes_sent4 !== 4'd1 || bytes_sent !== 16'd17) begin
            errors++;
            $display("FAIL wrap: drained=%0b sent4=%0d sent=%0d required 1/1/17", ok, bytes_sent4, bytes_sent);
        end
    endtask

    initial begin
        bus.data_out_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_enable();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side companion to the team's synchronous FIFO. It drains bytes through the FIFO's `rd_en`/`dout` port, whose data appears one cycle after the read, and re-times them into a registered valid/ready stream for a consumer such as the UART transmitter. It sustains one byte per cycle, loses and duplicates nothing under backpressure, and counts delivered bytes.

## Interface
- `WIDTH`, 8, data word width; must match the FIFO's `WIDTH`.
- `CNT_WIDTH`, 16, width of the delivered-byte counter.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  permits new FIFO reads; data already fetched still drains.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_rd_en`  out  1  FIFO `rd_en`; combinational.
- `fifo_dout`  in  WIDTH  FIFO `dout`; valid the cycle after an accepted read, then held.
- `data_out`  out  WIDTH  stream data; registered; holds the head entry.
- `data_out_valid`  out  1  stream valid; registered.
- `data_out_ready`  in  1  consumer ready.
- `bytes_sent`  out  CNT_WIDTH  count of stream handshakes; wraps modulo 2^CNT_WIDTH.

## Operation
- State:
  - 2-entry output buffer with `count` in 0..2 and a head pointer.
  - `pending` flag: a read was issued last cycle and its data is due on `fifo_dout` this cycle.
- Pop: `pop = data_out_valid && data_out_ready`.
- Issue rule: `fifo_rd_en = enable && !fifo_empty && (count + pending - pop) < 2`.
  - The buffer can never overflow.
  - Holds back-to-back reads when `data_out_ready` is high.
- `pending <= fifo_rd_en` each cycle.
- When `pending` is 1, `fifo_dout` is captured exactly once, into the tail entry.
  - `fifo_dout` is ignored whenever `pending` is 0. The FIFO holds stale data there.
- Simultaneous capture and pop: `count` is unchanged and the head advances.
  - If `count` was 1, the captured byte becomes the head in the same edge.
- `data_out` equals the head entry and `data_out_valid = (count != 0)`. Both are registered state, so there is no combinational path from `data_out_ready` to `data_out_valid`.
- If `data_out_ready` is low with valid high, `data_out` is held stable until the handshake.
- `bytes_sent` increments by 1 on each `pop` and wraps from all-ones to 0.
- `enable` deasserted: no new reads are issued. A pending byte is still captured, and buffered bytes still drain.
- Reset (asserted asynchronously at any time):
  - `count=0`, `pending=0`, `data_out=0`, `data_out_valid=0`, `bytes_sent=0`.
  - `fifo_rd_en` is low while `rst` is high.
  - A byte in flight at reset is discarded. The FIFO shares `rst`, so it empties too.

## Timing
- Latency: FIFO read issued in cycle N → captured at the end of N+1 → `data_out_valid` high in cycle N+2 (with an empty buffer).
- Throughput: 1 byte/cycle while the FIFO is non-empty, `enable=1` and `data_out_ready=1`.
- Stall of the consumer: at most 2 bytes are buffered. Reads stop the cycle the credit sum reaches 2 and resume the cycle a pop frees credit.
- FIFO goes empty mid-burst: `fifo_rd_en` drops the same cycle; already-issued bytes still emerge in order.
- Ordering: output order equals FIFO read order, always.

## Structure
- No shared package is needed. The buffer depth 2 is a local constant, and `WIDTH` is passed down from the parent that also instantiates the FIFO.
- One sub-module: `stream_skid_buffer`, a 2-entry registered buffer.
  - Ports: push/data in; valid/ready/data out; `count` output.
  - The top level holds `pending`, the issue rule and `bytes_sent`.

## Test plan
- Reset: FIFO preloaded with 0x11; `rst` pulsed mid-cycle → `data_out_valid=0`, `data_out=0x00`, `bytes_sent=0`, `fifo_rd_en=0` during reset.
- Single byte: push 0xA5, ready=1 → `fifo_rd_en` pulses 1 cycle; valid high 2 cycles later with `data_out=0xA5`; `bytes_sent=1`; no second read.
- Burst: push 0x00..0x1F (32 bytes), ready=1 → 32 consecutive valid cycles in order; `bytes_sent=32`; FIFO ends empty.
- Backpressure: 8 bytes queued, ready low 5 cycles then toggling every cycle → exactly 2 reads issued while stalled; `data_out` stable while stalled; output 8 bytes in order, none duplicated.
- Enable: deassert `enable` the cycle a read issues → that byte is still delivered, then no further reads; reassert → the remaining bytes follow.
- Wrap: with `CNT_WIDTH=4`, deliver 17 bytes → `bytes_sent=1`.
